// File: rtl/vga_sync_gen.sv
// vga_sync_gen: vertical line counter plus hsync/vsync/video_on decode for 640x480@60 VGA.
// Define VGA_SYNC_REG_OUT_EN to register hsync/vsync/video_on (one clk latency).
module vga_sync_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic       trig_v,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_TOTAL = 10'd525;
  logic [9:0] r_v_count;
  logic       r_frame_tick;
  logic       w_last_line;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_video_on;
  assign w_last_line = r_v_count == V_TOTAL - 10'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_count    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= trig_v && w_last_line;
      if (trig_v) r_v_count <= w_last_line ? '0 : r_v_count + 10'd1;
    end
  end
  // h_count beyond 799 falls outside every window, so it decodes as blanking
  assign w_hsync    = !(h_count >= H_VIS + H_FP && h_count < H_VIS + H_FP + H_SYNC);
  assign w_vsync    = !(r_v_count >= V_VIS + V_FP && r_v_count < V_VIS + V_FP + V_SYNC);
  assign w_video_on = h_count < H_VIS && r_v_count < V_VIS;
  assign v_count    = r_v_count;
  assign frame_tick = r_frame_tick;
`ifdef VGA_SYNC_REG_OUT_EN
  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else begin
      r_hsync    <= w_hsync;
      r_vsync    <= w_vsync;
      r_video_on <= w_video_on;
    end
  end
  // rst also masks the outputs directly so they are idle from the first reset cycle
  assign hsync    = r_hsync | rst;
  assign vsync    = r_vsync | rst;
  assign video_on = r_video_on & ~rst;
`else
  assign hsync    = w_hsync | rst;
  assign vsync    = w_vsync | rst;
  assign video_on = w_video_on & ~rst;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: random and directed stimulus against an arithmetic model of the VGA vertical timing.
module tb_vga_sync_gen;
`ifdef VGA_SYNC_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_v = 1'b0;
  logic [9:0] h_count = '0;
  logic [9:0] v_count;
  logic       hsync, vsync, video_on, frame_tick;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  vga_sync_gen dut (
    .clk(clk), .rst(rst), .h_count(h_count), .trig_v(trig_v),
    .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_tick(frame_tick)
  );
  function automatic bit f_hs(int h);
    return !(h >= 656 && h <= 751);
  endfunction
  function automatic bit f_vs(int v);
    return !(v >= 490 && v <= 491);
  endfunction
  function automatic bit f_vo(int h, int v);
    return h < 640 && v < 480;
  endfunction
  // model: line number is just the number of trig_v cycles since reset, mod 525
  int trigs = 0;
  bit m_ft = 0, m_hs_d = 1, m_vs_d = 1, m_vo_d = 0, armed = 0;
  always @(posedge clk) begin
    armed  <= 1;
    m_hs_d <= rst ? 1'b1 : f_hs(h_count);
    m_vs_d <= rst ? 1'b1 : f_vs(trigs % 525);
    m_vo_d <= rst ? 1'b0 : f_vo(h_count, trigs % 525);
    if (rst) begin
      trigs <= 0;
      m_ft  <= 0;
    end else begin
      m_ft <= trig_v && (trigs % 525 == 524);
      if (trig_v) trigs <= trigs + 1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      int ev;
      bit ehs, evs, evo;
      ev  = trigs % 525;
      ehs = rst | (LAT == 1 ? m_hs_d : f_hs(h_count));
      evs = rst | (LAT == 1 ? m_vs_d : f_vs(ev));
      evo = !rst && (LAT == 1 ? m_vo_d : f_vo(h_count, ev));
      tests++;
      if (v_count !== 10'(ev) || hsync !== ehs || vsync !== evs || video_on !== evo || frame_tick !== m_ft) begin
        fails++;
        $display("FAIL model t=%0t h=%0d: got v=%0d hs=%b vs=%b vo=%b ft=%b, want v=%0d hs=%b vs=%b vo=%b ft=%b",
                 $time, h_count, v_count, hsync, vsync, video_on, frame_tick, ev, ehs, evs, evo, m_ft);
      end
    end
  end
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic step(input logic r, input int h, input logic t);
    @(posedge clk);
    #1;
    rst = r;
    h_count = 10'(h);
    trig_v = t;
    @(negedge clk);
  endtask
  task automatic do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask
  initial begin
    int hs_lo, vo_n, vs_lines, ft_n, first_fall;
    int pix[8];
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst v_count", v_count, 0);
    chk("rst hsync", hsync, 1);
    chk("rst vsync", vsync, 1);
    chk("rst video_on", video_on, 0);
    chk("rst frame_tick", frame_tick, 0);
    step(0, 0, 0);
    // one full 800-pixel line on visible line 1
    hs_lo = 0; vo_n = 0; first_fall = -1;
    for (int h = 0; h < 800 + LAT; h++) begin
      step(0, h % 800, h == 0);
      if (!hsync) begin
        hs_lo++;
        if (first_fall < 0) first_fall = h;
      end
      if (video_on) vo_n++;
      if (h == 639 + LAT) chk("video_on at h=639", video_on, 1);
      if (h == 640 + LAT) chk("video_on at h=640", video_on, 0);
    end
    chk("hsync low clks per line", hs_lo, 96);
    chk("video_on clks per line", vo_n, 640);
    chk("hsync fall h", first_fall, 656 + LAT);
    // two frames of compressed lines; per-frame totals scale as 3 visible px, 2 sync px per line
    do_reset();
    hs_lo = 0; vo_n = 0; vs_lines = 0; ft_n = 0;
    for (int k = 0; k < 1050; k++) begin
      pix = '{0, $urandom_range(1, 638), 639, 640, 655, 656, 751, 752};
      for (int i = 0; i < 8; i++) begin
        step(0, pix[i], i == 0);
        if (!hsync) hs_lo++;
        if (video_on) vo_n++;
        if (frame_tick) begin
          ft_n++;
          chk("v_count at frame_tick", v_count, 0);
        end
        if (i == 3 && !vsync) vs_lines++;
        if (i == 2 && (k == 479 || k == 523 || k == 524 || k == 525)) chk("v_count seq", v_count, (k + 1) % 525);
      end
    end
    chk("hsync low px 2 frames", hs_lo, 2100);
    chk("video_on px 2 frames", vo_n, 2880);
    chk("vsync low lines 2 frames", vs_lines, 4);
    chk("frame_tick pulses", ft_n, 2);
    // visible-area bottom edge
    do_reset();
    for (int i = 0; i < 480; i++) step(0, 0, 1);
    step(0, 5, 0);
    step(0, 5, 0);
    chk("video_on at v=480", video_on, 0);
    // reset colliding with trig_v at line 300
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 0, 1);
    step(0, 0, 0);
    chk("v_count before rst", v_count, 300);
    step(1, 0, 1);
    chk("rst hsync mid", hsync, 1);
    chk("rst vsync mid", vsync, 1);
    chk("rst video_on mid", video_on, 0);
    step(0, 0, 0);
    chk("v_count after rst", v_count, 0);
    chk("no frame_tick from rst", frame_tick, 0);
    step(0, 0, 1);
    step(0, 5, 0);
    chk("first trig after rst", v_count, 1);
    // held trig_v and out-of-range h_count
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    step(0, 0, 0);
    chk("v_count before hold", v_count, 10);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 900, 0);
    step(0, 900, 0);
    chk("v_count after hold", v_count, 13);
    chk("video_on h=900", video_on, 0);
    chk("hsync h=900", hsync, 1);
    // random phase
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1023), $urandom_range(0, 3) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  pixel clock (25 MHz); the only clock.
- rst  input  1  synchronous, active-high reset.
- h_count  input  10  horizontal pixel counter from the upstream horizontal counter; free-runs 0..799.
- trig_v  input  1  one-cycle pulse, high while h_count==0 (end-of-line strobe).
- v_count  output  10  vertical line counter, 0..524.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- video_on  output  1  high only inside the 640x480 visible area.
- frame_tick  output  1  one-cycle pulse at the start of each frame.
REQ-002 Reset SHALL be synchronous and active-high on rst, sampled on posedge clk; there SHALL be one clock domain (clk).
REQ-003 Timing constants SHALL be localparams (name, default, meaning):
- H_VIS  640  visible pixels.
- H_FP  16  horizontal front porch.
- H_SYNC  96  hsync width.
- V_VIS  480  visible lines.
- V_FP  10  vertical front porch.
- V_SYNC  2  vsync width.
- V_TOTAL  525  lines per frame.

Function
REQ-004 v_count SHALL increment by 1 on each posedge clk where trig_v==1; otherwise it holds.
REQ-005 When trig_v==1 and v_count==V_TOTAL-1 (524), v_count SHALL wrap to 0.
REQ-006 frame_tick SHALL be high for exactly the one cycle after the 524->0 wrap; it SHALL be low at all other times.
REQ-007 hsync SHALL be 0 iff 656 <= h_count <= 751 (H_VIS+H_FP .. H_VIS+H_FP+H_SYNC-1); otherwise 1.
REQ-008 vsync SHALL be 0 iff 490 <= v_count <= 491; otherwise 1.
REQ-009 video_on SHALL be 1 iff h_count < 640 and v_count < 480.
REQ-010 An h_count value above 799 SHALL be treated as blanking: video_on=0, hsync=1, and v_count unaffected.
REQ-011 trig_v pulses longer than one cycle SHALL advance v_count once per high cycle; the block SHALL NOT edge-detect.
REQ-012 All comparisons SHALL be unsigned 10-bit; no output SHALL depend on anything other than h_count, trig_v, and internal state.

Reset
REQ-013 While rst==1, the outputs SHALL be:
- v_count=0
- frame_tick=0
- hsync=1
- vsync=1
- video_on=0
REQ-014 rst SHALL take priority over a simultaneous trig_v; that trig_v SHALL be lost.
REQ-015 Reset asserted mid-frame SHALL restart vertical counting at line 0 on the first trig_v after release.
REQ-016 frame_tick SHALL NOT pulse as a result of reset.

Configuration
REQ-017 Macro VGA_SYNC_REG_OUT_EN:
- Defined: hsync, vsync and video_on SHALL be registered, i.e. valid one clk after the h_count/v_count values that produce them.
- Undefined: they SHALL be combinational from the current h_count and v_count, with zero latency.
- v_count and frame_tick SHALL be registered in both builds.

Verification
REQ-018 Bench SHALL cover the following directed scenarios:
- Drive h_count 0..799 cyclically with trig_v at h_count==0 for 2 full frames -> v_count sequence 0..524,0.., frame_tick exactly 2 pulses, each one cycle after v_count returns to 0.
- Same stimulus -> per line, hsync low for exactly 96 clks (h_count 656..751); per frame, vsync low for exactly 2 lines (v_count 490,491).
- Count video_on cycles per frame -> exactly 307200 (640x480); video_on=0 at h_count=640 and at v_count=480.
- rst=1 together with trig_v at v_count=300 -> v_count=0, hsync=vsync=1, video_on=0, no frame_tick; the next trig_v after release gives v_count=1.
- trig_v held high for 3 cycles at v_count=10 -> v_count=13; with h_count forced to 900 -> video_on=0, hsync=1.
- Run with and without VGA_SYNC_REG_OUT_EN -> hsync falls at h_count 657 (registered) vs 656 (combinational).
